// File: rtl/div_issue_ctrl.sv
// Execute-stage initiator for the iterative divider: latches operands, holds start
// until done, stalls the pipeline, and issues a single HI/LO write per divide.
module div_issue_ctrl #(
   parameter int MAX_WAIT = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        stall_ext,
   input  logic        ex_div_req,
   input  logic        ex_div_unsigned,
   input  logic [31:0] ex_opa,
   input  logic [31:0] ex_opb,
   output logic        div_start,
   output logic        div_unsigned,
   output logic [31:0] div_opa,
   output logic [31:0] div_opb,
   input  logic [63:0] div_result,
   input  logic        div_done,
   output logic        stall_req,
   output logic        hilo_we,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata,
   output logic        timeout_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
   localparam logic [31:0]   ZDIV_LO   = 32'hFFFF_FFFF;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   opa_q, opa_d;
   logic [31:0]   opb_q, opb_d;
   logic          unsigned_q, unsigned_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic          timeout_q, timeout_d;

   // Next-state, operand latch and result capture; flush overrides every state.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      unsigned_d = unsigned_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      timeout_d  = timeout_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ex_div_req) begin
                  if (ex_opb != 32'd0) begin
                     opa_d      = ex_opa;
                     opb_d      = ex_opb;
                     unsigned_d = ex_div_unsigned;
                     cnt_d      = '0;
                     state_d    = S_BUSY;
                  end else begin
                     // Zero divisor never reaches the divider.
                     hi_d    = ex_opa;
                     lo_d    = ZDIV_LO;
                     state_d = S_DONE;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_BUSY: begin
               cnt_d = cnt_q + CW'(1);
               if (div_done) begin
                  hi_d    = div_result[63:32];
                  lo_d    = div_result[31:0];
                  state_d = S_DONE;
               end else if (cnt_q == WAIT_LAST) begin
                  timeout_d = 1'b1;
                  hi_d      = opa_q;
                  lo_d      = ZDIV_LO;
                  state_d   = S_DONE;
               end else begin
                  state_d = S_BUSY;
               end
            end
            S_DONE: begin
               if (!stall_ext) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         opa_q      <= 32'd0;
         opb_q      <= 32'd0;
         unsigned_q <= 1'b0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         unsigned_q <= unsigned_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         timeout_q  <= timeout_d;
      end
   end

   // Dropping start in DONE lets the divider clear its stage counter so it cannot retrigger.
   assign div_start    = (state_q == S_BUSY) && !flush;
   assign stall_req    = !flush && ((state_q == S_BUSY) || ((state_q == S_IDLE) && ex_div_req));
   assign hilo_we      = (state_q == S_DONE) && !stall_ext && !flush;
   assign div_opa      = opa_q;
   assign div_opb      = opb_q;
   assign div_unsigned = unsigned_q;
   assign hi_wdata     = hi_q;
   assign lo_wdata     = lo_q;
   assign timeout_err  = timeout_q;

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Execute-stage initiator for the iterative divider wrapper.
- Detects DIV/DIVU in EX, latches operands and holds them stable with start asserted until done, and stalls the pipeline meanwhile.
- Captures the 64-bit {remainder, quotient} result and issues a single HI/LO write.
- Handles flush, external stall while the result is pending, and a zero-divisor bypass.

Parameters:
- MAX_WAIT, 64, watchdog limit in BUSY cycles; must exceed the divider latency (36).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous reset, active-high (`RST_ENABLE)
- flush  in  1  pipeline flush/exception; kills the in-flight divide
- stall_ext  in  1  pipeline held by another source (memory etc.)
- ex_div_req  in  1  EX holds a valid DIV/DIVU
- ex_div_unsigned  in  1  1 = DIVU
- ex_opa  in  32  dividend (rs)
- ex_opb  in  32  divisor (rt)
- div_start  out  1  start to divider; held high for the whole operation
- div_unsigned  out  1  latched signedness
- div_opa  out  32  latched dividend
- div_opb  out  32  latched divisor
- div_result  in  64  {remainder, quotient} from divider
- div_done  in  1  divider done, one-cycle pulse
- stall_req  out  1  stall request to pipeline control
- hilo_we  out  1  HI/LO write enable, one-cycle pulse
- hi_wdata  out  32  remainder
- lo_wdata  out  32  quotient
- timeout_err  out  1  sticky; watchdog expired

Behaviour:
- Reset: state IDLE. div_start, stall_req, hilo_we and timeout_err are 0. div_opa, div_opb, div_unsigned, hi_wdata and lo_wdata are 0.
- States: IDLE, BUSY, DONE.
- Flush priority: flush is above everything except reset. In any state, flush forces IDLE next cycle, drops div_start and suppresses hilo_we that cycle and after.
- IDLE, ex_div_req=1, ex_opb!=0:
  - stall_req=1 combinationally.
  - Latch ex_opa, ex_opb and ex_div_unsigned into div_* registers.
  - Next state BUSY.
- IDLE, ex_div_req=1, ex_opb==0:
  - stall_req=1.
  - hi_wdata<=ex_opa, lo_wdata<=32'hFFFFFFFF.
  - Next state DONE. The divider is never started.
- BUSY:
  - div_start=1 and stall_req=1.
  - div_opa, div_opb and div_unsigned are frozen; the divider applies sign fix-up combinationally from them.
  - Wait counter increments each BUSY cycle.
  - On div_done: capture hi_wdata=div_result[63:32] and lo_wdata=div_result[31:0], then go to DONE.
  - When the counter reaches MAX_WAIT without done: set timeout_err, write the zero-divisor pattern, go to DONE.
- DONE:
  - div_start=0, so the divider clears its stage counter next edge and cannot retrigger.
  - stall_req=0.
  - stall_ext=0: hilo_we=1 this cycle, next state IDLE.
  - stall_ext=1: stay in DONE with hilo_we=0 and result held. The same instruction still in EX must not restart.
- Latency (divider latency 36): req seen in cycle 0; BUSY cycles 1..36 with done in cycle 36; DONE/hilo_we in cycle 37. EX occupancy is 38 cycles.
- Zero-divisor occupancy: 2 cycles.
- Back-to-back divides: a new ex_div_req seen in IDLE the cycle after DONE starts a fresh operation.
- div_done arriving in IDLE or DONE is ignored.
- ex_div_req dropping while BUSY without flush is ignored; the operation completes.
- Width rules: no arithmetic here beyond the counter. Results pass through unmodified. Overflow case 0x80000000 / -1 yields whatever the divider returns.

Test Plan:
- Signed DIV: opa=-7 (0xFFFFFFF9), opb=2 -> stall 37 cycles, then hilo_we pulse with lo=0xFFFFFFFD, hi=0xFFFFFFFF. div_opa and div_opb stable throughout BUSY.
- DIVU: opa=0xFFFFFFFF, opb=0x10 -> lo=0x0FFFFFFF, hi=0xF. Second DIVU issued the cycle after DONE (opa=100, opb=7) -> lo=14, hi=2, with a separate start assertion.
- Zero divisor: opa=0x1234, opb=0 -> div_start never high; hilo_we in cycle 1 with hi=0x1234, lo=0xFFFFFFFF.
- Flush at BUSY cycle 10 -> IDLE next cycle, div_start low, no hilo_we. A fresh DIV then produces the correct result.
- stall_ext=1 for 5 cycles at DONE -> no hilo_we and no restart during the hold. Exactly one hilo_we when stall_ext falls; result unchanged.
- Divider model that never pulses done, MAX_WAIT=64 -> timeout_err set after 64 BUSY cycles, hi=opa, lo=0xFFFFFFFF written. Reset clears timeout_err and returns to IDLE.
